// File: rtl/mux_128.sv
// Registered 2:1 selector for full-width vector operands: out takes ina or inb
// one clock after sampling, with out_valid marking data loaded since reset.
module mux_128 #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:WIDTH-1] ina,
    input  logic [0:WIDTH-1] inb,
    input  logic             sel,
    input  logic             en,
    output logic [0:WIDTH-1] out,
    output logic             out_valid
);

    // Handshake: there is no back-pressure. An edge with en=1 always captures,
    // and out_valid stays high from the first such edge until the next reset.
    logic [0:WIDTH-1] next_data;

    always_comb begin
        next_data = sel ? inb : ina;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out       <= next_data;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_128.sv
// Bench for mux_128: directed cases plus random traffic, checked by a
// behavioural model feeding an expected queue drained by a monitor.
module tb_mux_128;

    localparam int W = 128;

    logic         clk;
    logic         reset;
    logic [0:W-1] ina;
    logic [0:W-1] inb;
    logic         sel;
    logic         en;
    logic [0:W-1] out;
    logic         out_valid;

    logic [W:0]   exp_q[$];
    logic [0:W-1] mdl_out;
    logic         mdl_valid;
    int           n_checks;
    int           n_fail;

    localparam logic [0:W-1] ONES  = {32{4'h1}};
    localparam logic [0:W-1] FS    = {W{1'b1}};
    localparam logic [0:W-1] BITS  = {1'b1, {(W-2){1'b0}}, 1'b1};
    localparam logic [0:W-1] PAT_A = {16{8'hA5}};
    localparam logic [0:W-1] PAT_B = {16{8'h5A}};

    mux_128 #(.WIDTH(W)) dut (
        .ina       (ina),
        .inb       (inb),
        .out       (out),
        .sel       (sel),
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .out_valid (out_valid)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // monitor: one expected entry per clock edge, compared on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W:0] e;
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            if ({out_valid, out} !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL scoreboard t=%0t got valid=%0b out=%h want valid=%0b out=%h",
                         $time, out_valid, out, e[W], e[W-1:0]);
            end
        end
    end

    task automatic check(input string name, input logic [W:0] got, input logic [W:0] want);
        n_checks = n_checks + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // driver: apply inputs for one edge, push the model's post-edge result,
    // then return just after the following falling edge
    task automatic step(input logic r, input logic e, input logic s,
                        input logic [0:W-1] a, input logic [0:W-1] b);
        reset = r;
        en    = e;
        sel   = s;
        ina   = a;
        inb   = b;
        if (r) begin
            mdl_out   = '0;
            mdl_valid = 1'b0;
        end else if (e) begin
            mdl_out   = s ? b : a;
            mdl_valid = 1'b1;
        end
        exp_q.push_back({mdl_valid, mdl_out});
        @(negedge clk);
        #1;
    endtask

    function automatic logic [0:W-1] rand_w();
        logic [0:W-1] v;
        v = '0;
        for (int i = 0; i < W / 32; i++) v = {v[32:W-1], 32'($urandom())};
        return v;
    endfunction

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mdl_out   = '0;
        mdl_valid = 1'b0;
        reset = 1'b1;
        en    = 1'b0;
        sel   = 1'b0;
        ina   = '0;
        inb   = '0;
        #1;
        check("reset_state", {out_valid, out}, '0);
        @(negedge clk);
        #1;

        // released with en=0: nothing loads
        step(0, 0, 1, FS, FS);
        step(0, 0, 0, FS, FS);

        // basic select A, then B with one-cycle latency
        step(0, 1, 0, '0, ONES);
        step(0, 1, 1, '0, ONES);
        check("sel_b_latency", {out_valid, out}, {1'b1, ONES});

        // bit ordering: bit 0 is the MSB
        step(0, 1, 0, BITS, '0);
        check("bit0",  {{W{1'b0}}, out[0]},   {{W{1'b0}}, 1'b1});
        check("bit127", {{W{1'b0}}, out[W-1]}, {{W{1'b0}}, 1'b1});
        check("bits_mid", {3'b0, out[1:W-2]}, '0);
        step(0, 1, 1, BITS, '0);

        // hold for three edges, then load
        step(0, 1, 1, '0, ONES);
        for (int i = 0; i < 3; i++) step(0, 0, 0, FS, '0);
        check("hold", {out_valid, out}, {1'b1, ONES});
        step(0, 1, 0, FS, '0);

        // asynchronous reset between edges, held across a load edge
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {out_valid, out}, '0);
        mdl_out   = '0;
        mdl_valid = 1'b0;
        step(1, 1, 1, FS, ONES);
        step(0, 1, 1, FS, PAT_B);

        // per-cycle select toggling
        for (int i = 0; i < 4; i++) step(0, 1, i[0], PAT_A, PAT_B);
        check("toggle_last", {out_valid, out}, {1'b1, PAT_B});

        // random traffic with occasional reset
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), rand_w(), rand_w());

        // let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks = n_checks + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain got=%0d entries left want=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_128.md
Name: mux_128

Overview:
- Registered 2:1 selector for 128-bit vector operands in the vector datapath.
- Picks one of two 128-bit operand buses (ina or inb) with a single select bit.
- Presents the chosen value on a registered output one clock later.
- Used wherever the datapath chooses between two full-width vector sources, such as a register-file read vs. a forwarded/immediate operand.

Parameters:
- WIDTH, 128, data width of ina, inb and out. Must be ≥1. Only 128 is required to be verified.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset. Clears out and out_valid.
- ina  input  [0:WIDTH-1]  operand A. Bit 0 is the MSB, matching the datapath's big-endian bit numbering.
- inb  input  [0:WIDTH-1]  operand B, same numbering.
- sel  input  1  0 selects ina, 1 selects inb.
- en  input  1  load enable. 1 = capture the selection at the next rising edge; 0 = hold out.
- out  output  [0:WIDTH-1]  registered selected operand.
- out_valid  output  1  high once out holds data loaded since the last reset.

Interface order at instantiation: ina, inb, out, sel, then clk, reset, en, out_valid. Connect by name where possible.

Behaviour:
- Reset:
  - When reset is asserted, out and out_valid clear to 0 immediately, without waiting for clk.
  - Both stay 0 while reset is high.
  - Reset has priority over en and sel at all times, including when reset arrives in the same cycle as a load.
- Select function:
  - next = (sel == 0) ? ina : inb, bit-for-bit. Bit i of out comes from bit i of the selected input, with no reordering, inversion or lane swapping.
- Latency:
  - On each rising clk edge with reset low and en=1: out <= next, out_valid <= 1.
  - Data and select changes appear on out exactly one rising edge after they are sampled.
- Hold:
  - On a rising edge with en=0, out and out_valid keep their previous values.
  - ina, inb and sel changes are ignored in that case.
- Combinational isolation:
  - out depends only on the register. No combinational path from ina, inb or sel to out.
- Unknown select:
  - An X/Z on sel in simulation is not defined behaviour. Synthesis treats sel as a plain bit.
  - The bench must not drive sel=X while en=1.
- Back-to-back operation:
  - sel may toggle every cycle. Each edge captures the inputs present at that edge, with no bubbles.
- Release from reset:
  - The first rising edge with reset low and en=1 loads data and sets out_valid.
  - With en=0 after release, out stays 0 and out_valid stays 0.
- Structure:
  - WIDTH independent 2:1 selects feeding a WIDTH-bit register, plus one valid flop.
  - No other state, no FSM, no arithmetic.

Test Plan:
- Basic select A:
  - Assert then release reset, en=1.
  - Drive ina=128'h0000_0000_0000_0000_0000_0000_0000_0000, inb=128'h1111_1111_1111_1111_1111_1111_1111_1111, sel=0.
  - After one rising edge: out=all zeros, out_valid=1.
- Basic select B:
  - Same operands, then sel=1.
  - After the next rising edge: out=128'h1111…1111.
  - Before that edge, out is still zeros, confirming one-cycle latency.
- Bit ordering:
  - ina=128'h8000_0000_0000_0000_0000_0000_0000_0001, inb=0, sel=0.
  - After an edge: out[0]=1, out[127]=1, all other bits 0.
  - Then sel=1: after the next edge, out=0.
- Hold:
  - With out=128'h1111…1111, set en=0, sel=0, ina=128'hFFFF…FFFF, and clock 3 edges.
  - out stays 128'h1111…1111.
  - Then en=1: after one edge, out=128'hFFFF…FFFF.
- Asynchronous reset mid-operation:
  - With out=128'hFFFF…FFFF, assert reset between clock edges.
  - out=0 and out_valid=0 immediately, before the next edge.
  - Hold reset across an edge with en=1, sel=1: out stays 0.
  - After release, the next edge loads inb.
- Per-cycle toggling:
  - en=1, ina=128'hA5A5…A5A5, inb=128'h5A5A…5A5A, sel toggles 0,1,0,1 on successive edges.
  - out follows A5…, 5A…, A5…, 5A…, each one edge after the sel value was sampled.
